// File: rtl/mem_wb_elastic_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, bubble-squashed register write enable and retired-instruction counter.
module mem_wb_elastic_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 16,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wreg,
    input  logic              in_m2reg,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_rdrt,
    input  logic [TAG_W-1:0]  in_ins_type,
    input  logic [TAG_W-1:0]  in_ins_number,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wreg,
    output logic              out_m2reg,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_rdrt,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [TAG_W-1:0]  out_ins_type,
    output logic [TAG_W-1:0]  out_ins_number,
    output logic [CNT_W-1:0]  retired_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  rdrt;
        logic [TAG_W-1:0]  ins_type;
        logic [TAG_W-1:0]  ins_number;
    } entry_t;

    logic [1:0]       state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    entry_t           in_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             drain;

    assign in_e = '{wreg:       in_wreg,
                    m2reg:      in_m2reg,
                    mem_data:   in_mem_data,
                    alu:        in_alu,
                    rdrt:       in_rdrt,
                    ins_type:   in_ins_type,
                    ins_number: in_ins_number};

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + CNT_W'(drain);
        // flush wins over any accept in the same cycle; a concurrent drain is still counted above
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_e;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    case ({accept, drain})
                        2'b11: head_d = in_e;
                        2'b10: begin
                            if (SKID_EN) begin
                                skid_d  = in_e;
                                state_d = TWO;
                            end
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (drain) begin
                        head_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    // With the skid buffer, in_ready is a flop so it never combinationally depends on out_ready.
    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != TWO);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    assign out_wreg       = head_q.wreg & out_valid;
    assign out_m2reg      = head_q.m2reg;
    assign out_mem_data   = head_q.mem_data;
    assign out_alu        = head_q.alu;
    assign out_rdrt       = head_q.rdrt;
    assign out_wb_data    = head_q.m2reg ? head_q.mem_data : head_q.alu;
    assign out_ins_type   = head_q.ins_type;
    assign out_ins_number = head_q.ins_number;
    assign retired_count  = cnt_q;

endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// Scoreboard bench for mem_wb_elastic_stage: one instance with the skid buffer and one
// without, both CNT_W=4, driven through the same directed scenarios in turn.
module tb_mem_wb_elastic_stage;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rdrt;
        logic [3:0]  num;
        logic [31:0] wb;
    } stim_t;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  rdrt;
        logic [3:0]  num;
        logic [31:0] wb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst[2];
    logic        flush[2];
    logic        in_valid[2];
    logic        in_ready[2];
    logic        in_wreg[2];
    logic        in_m2reg[2];
    logic [31:0] in_mem_data[2];
    logic [31:0] in_alu[2];
    logic [4:0]  in_rdrt[2];
    logic [3:0]  in_ins_type[2];
    logic [3:0]  in_ins_number[2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic        out_wreg[2];
    logic        out_m2reg[2];
    logic [31:0] out_mem_data[2];
    logic [31:0] out_alu[2];
    logic [4:0]  out_rdrt[2];
    logic [31:0] out_wb_data[2];
    logic [3:0]  out_ins_type[2];
    logic [3:0]  out_ins_number[2];
    logic [3:0]  retired_count[2];

    stim_t cur[2];
    exp_t  q0[$];
    exp_t  q1[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    mem_wb_elastic_stage #(.DATA_W(32), .REG_W(5), .TAG_W(4), .CNT_W(4), .SKID_EN(1'b1)) u_skid (
        .clk(clk), .rst(rst[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_wreg(in_wreg[0]), .in_m2reg(in_m2reg[0]),
        .in_mem_data(in_mem_data[0]), .in_alu(in_alu[0]), .in_rdrt(in_rdrt[0]),
        .in_ins_type(in_ins_type[0]), .in_ins_number(in_ins_number[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_wreg(out_wreg[0]), .out_m2reg(out_m2reg[0]),
        .out_mem_data(out_mem_data[0]), .out_alu(out_alu[0]), .out_rdrt(out_rdrt[0]),
        .out_wb_data(out_wb_data[0]), .out_ins_type(out_ins_type[0]),
        .out_ins_number(out_ins_number[0]), .retired_count(retired_count[0])
    );

    mem_wb_elastic_stage #(.DATA_W(32), .REG_W(5), .TAG_W(4), .CNT_W(4), .SKID_EN(1'b0)) u_noskid (
        .clk(clk), .rst(rst[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_wreg(in_wreg[1]), .in_m2reg(in_m2reg[1]),
        .in_mem_data(in_mem_data[1]), .in_alu(in_alu[1]), .in_rdrt(in_rdrt[1]),
        .in_ins_type(in_ins_type[1]), .in_ins_number(in_ins_number[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_wreg(out_wreg[1]), .out_m2reg(out_m2reg[1]),
        .out_mem_data(out_mem_data[1]), .out_alu(out_alu[1]), .out_rdrt(out_rdrt[1]),
        .out_wb_data(out_wb_data[1]), .out_ins_type(out_ins_type[1]),
        .out_ins_number(out_ins_number[1]), .retired_count(retired_count[1])
    );

    function automatic stim_t mk(input logic [31:0] alu, input logic [31:0] mem, input logic m2reg,
                                 input logic wreg, input logic [4:0] rdrt, input logic [3:0] num,
                                 input logic [31:0] wb);
        stim_t s;
        s.wreg = wreg; s.m2reg = m2reg; s.mem = mem; s.alu = alu;
        s.rdrt = rdrt; s.num = num; s.wb = wb;
        return s;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    task automatic sb_push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic sb_clear(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic chk_empty(input int k);
        chk("sb_leftover", k, (k == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'd0);
    endtask

    // Monitor: compares every handshake against the scoreboard; flush discards what is left.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst[k]) begin
                exp_t e;
                exp_t a;
                if (!out_valid[k]) begin
                    checks++;
                    if (out_wreg[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL bubble_wreg dut%0d: got %0b want 0", k, out_wreg[k]);
                    end
                end
                if (out_valid[k] && out_ready[k]) begin
                    a = {out_wreg[k], out_rdrt[k], out_ins_number[k], out_wb_data[k]};
                    checks++;
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        errors++;
                        $display("FAIL unexpected_out dut%0d: got %0h want none", k, a);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        if (a !== e) begin
                            errors++;
                            $display("FAIL out_entry dut%0d: got %0h want %0h", k, a, e);
                        end
                    end
                end
                if (flush[k]) sb_clear(k);
            end
        end
    end

    task automatic present(input int k, input stim_t s);
        cur[k]           = s;
        in_valid[k]      = 1'b1;
        in_wreg[k]       = s.wreg;
        in_m2reg[k]      = s.m2reg;
        in_mem_data[k]   = s.mem;
        in_alu[k]        = s.alu;
        in_rdrt[k]       = s.rdrt;
        in_ins_type[k]   = 4'h3;
        in_ins_number[k] = s.num;
    endtask

    task automatic tick(input int k, output bit acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid[k] && in_ready[k];
        if (acc && !flush[k]) begin
            e = {cur[k].wreg, cur[k].rdrt, cur[k].num, cur[k].wb};
            sb_push(k, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input stim_t s);
        bit acc;
        int n;
        present(k, s);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 30) begin
            tick(k, acc);
            n++;
        end
        in_valid[k] = 1'b0;
        if (!acc) chk("send_timeout", k, 32'd0, 32'd1);
    endtask

    task automatic idle(input int k, input int n);
        bit acc;
        in_valid[k] = 1'b0;
        repeat (n) tick(k, acc);
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1; flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
        sb_clear(k);
        repeat (2) @(posedge clk);
        #1 rst[k] = 1'b0;
    endtask

    task automatic run_all(input int k);
        stim_t lst[3];
        bit    acc;
        int    idx;

        // reset state
        do_reset(k);
        chk("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
        chk("rst_out_wreg",  k, 32'(out_wreg[k]),  32'd0);
        chk("rst_retired",   k, 32'(retired_count[k]), 32'd0);
        chk("rst_in_ready",  k, 32'(in_ready[k]),  32'd1);

        // free-flowing stream, 1-cycle latency
        out_ready[k] = 1'b1;
        send(k, mk(32'h10, 32'h0, 1'b0, 1'b1, 5'd1, 4'd1, 32'h10));
        chk("lat_valid", k, 32'(out_valid[k]), 32'd1);
        chk("lat_wb0",   k, out_wb_data[k], 32'h10);
        send(k, mk(32'h20, 32'h0, 1'b0, 1'b1, 5'd2, 4'd2, 32'h20));
        chk("lat_wb1",   k, out_wb_data[k], 32'h20);
        send(k, mk(32'h30, 32'h0, 1'b0, 1'b1, 5'd3, 4'd3, 32'h30));
        chk("lat_wb2",   k, out_wb_data[k], 32'h30);
        idle(k, 3);
        chk("stream_retired", k, 32'(retired_count[k]), 32'd3);
        chk_empty(k);

        // back-pressure for 3 cycles
        do_reset(k);
        lst[0] = mk(32'hA1, 32'h0, 1'b0, 1'b1, 5'd4, 4'd4, 32'hA1);
        lst[1] = mk(32'hB2, 32'h0, 1'b0, 1'b1, 5'd5, 4'd5, 32'hB2);
        lst[2] = mk(32'hC3, 32'h0, 1'b0, 1'b1, 5'd6, 4'd6, 32'hC3);
        send(k, lst[0]);
        idx = 1;
        present(k, lst[1]);
        repeat (3) begin
            tick(k, acc);
            if (acc && idx < 2) begin
                idx++;
                present(k, lst[idx]);
            end
        end
        chk("stall_in_ready", k, 32'(in_ready[k]), 32'd0);
        chk("stall_valid",    k, 32'(out_valid[k]), 32'd1);
        chk("stall_head",     k, out_wb_data[k], 32'hA1);
        out_ready[k] = 1'b1;
        while (idx < 3) begin
            send(k, lst[idx]);
            idx++;
        end
        idle(k, 4);
        chk("stall_retired", k, 32'(retired_count[k]), 32'd3);
        chk_empty(k);

        // flush while full and with a new entry offered
        do_reset(k);
        send(k, lst[0]);
        present(k, lst[1]);
        tick(k, acc);
        if (acc) present(k, lst[2]);
        flush[k] = 1'b1;
        tick(k, acc);
        flush[k] = 1'b0;
        in_valid[k] = 1'b0;
        chk("fl_valid",   k, 32'(out_valid[k]), 32'd0);
        chk("fl_wreg",    k, 32'(out_wreg[k]),  32'd0);
        chk("fl_wb",      k, out_wb_data[k], 32'd0);
        chk("fl_alu",     k, out_alu[k], 32'd0);
        chk("fl_mem",     k, out_mem_data[k], 32'd0);
        chk("fl_m2reg",   k, 32'(out_m2reg[k]), 32'd0);
        chk("fl_rdrt",    k, 32'(out_rdrt[k]), 32'd0);
        chk("fl_type",    k, 32'(out_ins_type[k]), 32'd0);
        chk("fl_num",     k, 32'(out_ins_number[k]), 32'd0);
        chk("fl_retired", k, 32'(retired_count[k]), 32'd0);
        idle(k, 2);
        chk("fl_stays_empty", k, 32'(out_valid[k]), 32'd0);

        // flush coinciding with a drain: drain counts, new entry is discarded
        do_reset(k);
        send(k, lst[0]);
        out_ready[k] = 1'b1;
        flush[k] = 1'b1;
        present(k, lst[1]);
        tick(k, acc);
        flush[k] = 1'b0;
        in_valid[k] = 1'b0;
        chk("fld_retired", k, 32'(retired_count[k]), 32'd1);
        chk("fld_valid",   k, 32'(out_valid[k]), 32'd0);
        idle(k, 2);
        chk("fld_discard", k, 32'(out_valid[k]), 32'd0);
        chk_empty(k);

        // write-back source select and squashed bubble
        do_reset(k);
        out_ready[k] = 1'b1;
        send(k, mk(32'h1234, 32'hDEADBEEF, 1'b1, 1'b1, 5'd7, 4'd7, 32'hDEADBEEF));
        chk("m2reg_wb", k, out_wb_data[k], 32'hDEADBEEF);
        send(k, mk(32'h55, 32'h66, 1'b0, 1'b0, 5'd8, 4'd8, 32'h55));
        chk("nowreg_wreg", k, 32'(out_wreg[k]), 32'd0);
        idle(k, 1);
        chk("bubble_valid", k, 32'(out_valid[k]), 32'd0);
        chk("bubble_wreg",  k, 32'(out_wreg[k]), 32'd0);
        chk_empty(k);

        // counter wrap: 17 drains mod 16
        do_reset(k);
        out_ready[k] = 1'b1;
        for (int i = 0; i < 17; i++)
            send(k, mk(32'h100 + 32'(i), 32'h0, 1'b0, 1'b1, 5'(i), 4'(i), 32'h100 + 32'(i)));
        idle(k, 2);
        chk("wrap_retired", k, 32'(retired_count[k]), 32'd1);
        chk_empty(k);

        // asynchronous reset in the middle of a stalled stream
        do_reset(k);
        out_ready[k] = 1'b1;
        send(k, lst[0]);
        idle(k, 1);
        out_ready[k] = 1'b0;
        send(k, lst[1]);
        present(k, lst[2]);
        tick(k, acc);
        rst[k] = 1'b1;
        in_valid[k] = 1'b0;
        #1;
        chk("arst_valid",    k, 32'(out_valid[k]), 32'd0);
        chk("arst_wreg",     k, 32'(out_wreg[k]), 32'd0);
        chk("arst_wb",       k, out_wb_data[k], 32'd0);
        chk("arst_retired",  k, 32'(retired_count[k]), 32'd0);
        chk("arst_in_ready", k, 32'(in_ready[k]), 32'd1);
        sb_clear(k);
        @(posedge clk);
        #1 rst[k] = 1'b0;
        out_ready[k] = 1'b1;
        send(k, mk(32'hE5, 32'h0, 1'b0, 1'b1, 5'd9, 4'd9, 32'hE5));
        chk("arst_first", k, out_wb_data[k], 32'hE5);
        idle(k, 2);
        chk("arst_after_retired", k, 32'(retired_count[k]), 32'd1);
        chk_empty(k);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            in_wreg[k] = 1'b0; in_m2reg[k] = 1'b0; in_mem_data[k] = '0; in_alu[k] = '0;
            in_rdrt[k] = '0; in_ins_type[k] = '0; in_ins_number[k] = '0;
            cur[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        run_all(0);
        run_all(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
